mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 18 +
 rtl/mem_access_ctrl_if.sv | 37 +++
 rtl/mem_wait_timer.sv | 39 +++
 rtl/mem_access_ctrl.sv | 121 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage data memory access controller.
package mem_access_ctrl_pkg;

  localparam int unsigned XLEN_DEF           = 64;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_e;

  function automatic logic is_dword_aligned(input logic [2:0] lsb);
    return lsb == 3'b000;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and data-memory-side signals of the MEM-stage access controller.
interface mem_access_ctrl_if
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
);

  logic            mem_read;
  logic            mem_write;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            dmem_ready;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            stall;
  logic [XLEN-1:0] rdata_out;
  logic            rdata_valid;
  logic            err_timeout;
  logic            err_misalign;
  logic            err_illegal;

  modport slave (
    input  mem_read, mem_write, addr, wdata, dmem_ready, dmem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, stall, rdata_out,
           rdata_valid, err_timeout, err_misalign, err_illegal
  );

  modport master (
    output mem_read, mem_write, addr, wdata, dmem_ready, dmem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, stall, rdata_out,
           rdata_valid, err_timeout, err_misalign, err_illegal
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter: clears on request launch, counts unanswered BUSY cycles.
module mem_wait_timer
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LAST);

  // Saturates at LAST so the count can never wrap back below the expiry point.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: launches one data memory access per load/store,
// stalls the pipeline until it completes or times out, and records errors.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned XLEN           = XLEN_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_access_ctrl_if.slave  bus
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            we_q, we_d;
  logic            err_to_q, err_to_d;
  logic            err_mis_q, err_mis_d;
  logic            err_ill_q, err_ill_d;

  logic in_idle, one_op, both_ops, aligned, access;
  logic tmr_clr, tmr_en, tmr_expired;

  mem_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // Qualifying with reset_n keeps stall low while reset is held, even if
  // EX/MEM still presents a load or store.
  always_comb begin
    in_idle  = (state_q == IDLE) && reset_n;
    one_op   = bus.mem_read ^ bus.mem_write;
    both_ops = bus.mem_read & bus.mem_write;
    aligned  = is_dword_aligned(bus.addr[2:0]);
    access   = in_idle && one_op && aligned;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    err_to_d  = err_to_q;
    err_mis_d = err_mis_q;
    err_ill_d = err_ill_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;

    if (in_idle && both_ops) err_ill_d = 1'b1;
    if (in_idle && one_op && !aligned) err_mis_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (access) begin
          state_d = BUSY;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          we_d    = bus.mem_write;
          tmr_clr = 1'b1;
        end
      end
      BUSY: begin
        if (bus.dmem_ready) begin
          state_d = DONE;
          if (!we_q) rdata_d = bus.dmem_rdata;
        end else if (tmr_expired) begin
          state_d  = ABORT;
          err_to_d = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      err_to_q  <= 1'b0;
      err_mis_q <= 1'b0;
      err_ill_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      err_to_q  <= err_to_d;
      err_mis_q <= err_mis_d;
      err_ill_q <= err_ill_d;
    end
  end

  assign bus.dmem_req     = (state_q == BUSY);
  assign bus.dmem_we      = we_q;
  assign bus.dmem_addr    = addr_q;
  assign bus.dmem_wdata   = wdata_q;
  assign bus.stall        = access || (state_q == BUSY);
  assign bus.rdata_out    = rdata_q;
  assign bus.rdata_valid  = (state_q == DONE) && !we_q;
  assign bus.err_timeout  = err_to_q;
  assign bus.err_misalign = err_mis_q;
  assign bus.err_illegal  = err_ill_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the driver predicts each instruction's
// outcome from its latency and operands, and a monitor checks what the DUT shows.
module tb_mem_access_ctrl;

  localparam int unsigned XL = 64;
  localparam int          TO = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.XLEN(XL)) bus ();

  mem_access_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .XLEN           (XL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    int          stall_cyc;
    int          req_cyc;
    int          valid_cyc;
    logic [63:0] rdata;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        we;
    logic [2:0]  flags;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  // Reference model state: sticky error flags and last completed load value.
  logic        m_to, m_mis, m_ill;
  logic [63:0] m_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic respond(input int lat, input logic [63:0] rdv, inout int busy_k);
    if (bus.dmem_req) begin
      busy_k++;
      bus.dmem_ready = (busy_k == lat + 1);
      bus.dmem_rdata = bus.dmem_ready ? rdv : {$urandom, $urandom};
    end else begin
      bus.dmem_ready = 1'($urandom_range(0, 1));
      bus.dmem_rdata = {$urandom, $urandom};
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.addr       = {$urandom, $urandom};
      bus.wdata      = {$urandom, $urandom};
      bus.dmem_ready = 1'($urandom_range(0, 1));
      bus.dmem_rdata = {$urandom, $urandom};
    end
  endtask

  // lat = wait cycles before dmem_ready; any lat >= TO means memory never answers in time.
  task automatic run_txn(input logic rd, input logic wr, input logic [63:0] a,
                         input logic [63:0] wd, input int lat, input logic [63:0] rdv);
    exp_t e;
    int   busy_k = 0;
    int   n = 0;
    logic ok;
    ok = (rd ^ wr) && (a[2:0] == 3'b000);
    if (rd && wr) m_ill = 1'b1;
    if ((rd ^ wr) && (a[2:0] != 3'b000)) m_mis = 1'b1;
    e.addr = a; e.wdata = wd; e.we = wr;
    e.stall_cyc = 0; e.req_cyc = 0; e.valid_cyc = 0;
    if (ok) begin
      if (lat < TO) begin
        e.stall_cyc = 2 + lat;
        e.req_cyc   = lat + 1;
        if (rd) begin
          e.valid_cyc = 1;
          m_rdata     = rdv;
        end
      end else begin
        e.stall_cyc = 1 + TO;
        e.req_cyc   = TO;
        m_to        = 1'b1;
      end
    end
    e.rdata = m_rdata;
    e.flags = {m_to, m_mis, m_ill};
    sb_q.push_back(e);

    @(negedge clk);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.wdata     = wd;
    forever begin
      respond(lat, rdv, busy_k);
      #1;
      if (!bus.stall) break;
      n++;
      if (n > TO + 8) begin
        n_cmp++;
        n_fail++;
        $display("FAIL txn_cycle_bound: stall still high after %0d cycles, required release", n);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic reset_mid_access();
    exp_t e;
    int   busy_k = 0;
    int   n = 0;
    e.addr = 64'h3F0; e.wdata = {$urandom, $urandom}; e.we = 1'b0;
    e.stall_cyc = 0; e.req_cyc = 0; e.valid_cyc = 0; e.rdata = m_rdata;
    e.flags = {m_to, m_mis, m_ill};
    sb_q.push_back(e);
    @(negedge clk);
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b0;
    bus.addr      = e.addr;
    bus.wdata     = e.wdata;
    forever begin
      respond(1000, 64'h0, busy_k);
      if (busy_k == 3) break;
      n++;
      if (n > 10) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rst_busy_bound: third BUSY cycle not reached after %0d cycles", n);
        break;
      end
      @(negedge clk);
    end
    #1;
    reset_n = 1'b0;
    sb_q.delete();
    m_to = 1'b0; m_mis = 1'b0; m_ill = 1'b0; m_rdata = '0;
    #1;
    chk("rst_dmem_req",    64'(bus.dmem_req), 64'(0));
    chk("rst_stall",       64'(bus.stall), 64'(0));
    chk("rst_rdata_valid", 64'(bus.rdata_valid), 64'(0));
    chk("rst_flags",       64'({bus.err_timeout, bus.err_misalign, bus.err_illegal}), 64'(0));
    chk("rst_rdata_out",   bus.rdata_out, m_rdata);
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: accumulates per-instruction observations, pops on the instruction's last cycle.
  int          st_cnt = 0, rq_cnt = 0, v_cnt = 0;
  logic        pend = 1'b0;
  logic [2:0]  pend_flags;
  exp_t        mon_e;

  always @(negedge clk) begin
    #2;
    if (!reset_n) begin
      st_cnt = 0; rq_cnt = 0; v_cnt = 0; pend = 1'b0;
    end else begin
      if (pend) begin
        chk("err_flags", 64'({bus.err_timeout, bus.err_misalign, bus.err_illegal}), 64'(pend_flags));
        pend = 1'b0;
      end
      if (bus.mem_read || bus.mem_write) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_empty: instruction present with no expected entry at %0t", $time);
        end else begin
          if (bus.stall) st_cnt++;
          if (bus.rdata_valid) v_cnt++;
          if (bus.dmem_req) begin
            rq_cnt++;
            chk("dmem_addr",  bus.dmem_addr, sb_q[0].addr);
            chk("dmem_wdata", bus.dmem_wdata, sb_q[0].wdata);
            chk("dmem_we",    64'(bus.dmem_we), 64'(sb_q[0].we));
          end
          if (!bus.stall) begin
            mon_e = sb_q.pop_front();
            chk("stall_cycles", 64'(st_cnt), 64'(mon_e.stall_cyc));
            chk("req_cycles",   64'(rq_cnt), 64'(mon_e.req_cyc));
            chk("valid_cycles", 64'(v_cnt),  64'(mon_e.valid_cyc));
            chk("rdata_out",    bus.rdata_out, mon_e.rdata);
            pend_flags = mon_e.flags;
            pend = 1'b1;
            st_cnt = 0; rq_cnt = 0; v_cnt = 0;
          end
        end
      end else begin
        chk("idle_dmem_req",    64'(bus.dmem_req), 64'(0));
        chk("idle_rdata_valid", 64'(bus.rdata_valid), 64'(0));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    logic        rd, wr;
    int          k, lat;

    reset_n = 1'b0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.dmem_ready = 1'b0; bus.dmem_rdata = '0;
    m_to = 1'b0; m_mis = 1'b0; m_ill = 1'b0; m_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_dmem_req",   64'(bus.dmem_req), 64'(0));
    chk("reset_dmem_we",    64'(bus.dmem_we), 64'(0));
    chk("reset_dmem_addr",  bus.dmem_addr, 64'(0));
    chk("reset_dmem_wdata", bus.dmem_wdata, 64'(0));
    chk("reset_stall",      64'(bus.stall), 64'(0));
    chk("reset_rdata_out",  bus.rdata_out, 64'(0));
    chk("reset_valid",      64'(bus.rdata_valid), 64'(0));
    chk("reset_flags",      64'({bus.err_timeout, bus.err_misalign, bus.err_illegal}), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    run_txn(1'b1, 1'b0, 64'h100, 64'h0,  0, 64'hDEADBEEF);
    idle(1);
    run_txn(1'b0, 1'b1, 64'h208, 64'h55, 5, {$urandom, $urandom});
    run_txn(1'b1, 1'b0, 64'h300, 64'h0,  1000, {$urandom, $urandom});
    idle(1);
    run_txn(1'b1, 1'b0, 64'h103, 64'h0,  0, {$urandom, $urandom});
    run_txn(1'b1, 1'b1, 64'h400, 64'h9,  0, {$urandom, $urandom});
    run_txn(1'b1, 1'b0, 64'h408, 64'h0,  2, {$urandom, $urandom});
    run_txn(1'b1, 1'b0, 64'h410, 64'h0,  TO - 1, {$urandom, $urandom});
    run_txn(1'b0, 1'b1, 64'h418, 64'h77, TO, {$urandom, $urandom});
    idle(1);
    reset_mid_access();
    run_txn(1'b1, 1'b0, 64'h500, 64'h0,  1, {$urandom, $urandom});
    idle(1);

    for (int i = 0; i < 60; i++) begin
      k   = int'($urandom_range(0, 9));
      a   = {$urandom, $urandom};
      a[2:0] = 3'b000;
      lat = int'($urandom_range(0, 6));
      rd  = (k < 4) || (k == 9) || ((k == 7) && $urandom_range(0, 1) == 1);
      wr  = ((k >= 4) && (k < 7)) || (k == 8) || ((k == 7) && !rd);
      if (k == 8) rd = 1'b1;
      if (k == 7) a[2:0] = 3'($urandom_range(1, 7));
      if (k == 9) lat = int'($urandom_range(TO - 2, TO + 2));
      run_txn(rd, wr, a, {$urandom, $urandom}, lat, {$urandom, $urandom});
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end

    idle(3);
    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
